// File: rtl/id_issue_stage.sv
// Decode/issue stage: IF/ID and ID/EX registers with a one-bubble load-use interlock.
// Optional macro STALL_CNT_EN adds a live load-use bubble counter on perf_stall_cnt.
module id_issue_stage #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int unsigned PERF_W   = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              if_valid,
    input  logic [31:0]       if_pc,
    input  logic [31:0]       if_inst,
    input  logic              ex_ready,
    input  logic              flush,
    output logic [4:0]        raddr1,
    output logic [4:0]        raddr2,
    input  logic [31:0]       rdata1,
    input  logic [31:0]       rdata2,
    output logic              stall_to_if,
    output logic              idex_valid,
    output logic [31:0]       idex_pc,
    output logic [31:0]       idex_inst,
    output logic [31:0]       idex_src1,
    output logic [31:0]       idex_src2,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    logic            ifid_valid;
    logic [XLEN-1:0] ifid_pc;
    logic [XLEN-1:0] ifid_inst;

    logic            ex_load;
    logic [RW-1:0]   load_dest;
    logic            hazard;

    assign raddr1 = ifid_inst[25:21];
    assign raddr2 = ifid_inst[20:16];

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        ex_load   = idex_valid & (idex_inst[31:29] == 3'b100);
        load_dest = idex_inst[20:16];
        hazard    = ifid_valid & ex_load & (load_dest != RW'(0)) &
                    ((load_dest == ifid_inst[25:21]) | (load_dest == ifid_inst[20:16]));
    end

    assign stall_to_if = resetn & ~flush & (~ex_ready | hazard);

    // IF/ID register: holds on EX busy or hazard
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= XLEN'(0);
            ifid_inst  <= NOP_INST;
        end else if (flush) begin
            ifid_valid <= 1'b0;
            ifid_inst  <= NOP_INST;
        end else if (ex_ready && !hazard) begin
            if (if_valid) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= if_pc;
                ifid_inst  <= if_inst;
            end else begin
                ifid_valid <= 1'b0;
                ifid_inst  <= NOP_INST;
            end
        end
    end

    // ID/EX register: bubble on hazard, freeze on EX busy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idex_valid <= 1'b0;
            idex_pc    <= XLEN'(0);
            idex_inst  <= NOP_INST;
            idex_src1  <= XLEN'(0);
            idex_src2  <= XLEN'(0);
        end else if (flush) begin
            idex_valid <= 1'b0;
            idex_inst  <= NOP_INST;
            idex_src1  <= XLEN'(0);
            idex_src2  <= XLEN'(0);
        end else if (ex_ready) begin
            if (hazard) begin
                idex_valid <= 1'b0;
                idex_pc    <= XLEN'(0);
                idex_inst  <= NOP_INST;
                idex_src1  <= XLEN'(0);
                idex_src2  <= XLEN'(0);
            end else begin
                idex_valid <= ifid_valid;
                idex_pc    <= ifid_pc;
                idex_inst  <= ifid_inst;
                idex_src1  <= rdata1;
                idex_src2  <= rdata2;
            end
        end
    end

`ifdef STALL_CNT_EN
    // Counts only bubbles actually injected, wraps naturally
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_stall_cnt <= PERF_W'(0);
        end else if (!flush && ex_ready && hazard) begin
            perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
        end
    end
`else
    assign perf_stall_cnt = PERF_W'(0);
`endif

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: directed scenarios plus randomized traffic against a slot-level model.
module tb_id_issue_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        ex_ready;
    logic        flush;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        stall_to_if;
    logic        idex_valid;
    logic [31:0] idex_pc;
    logic [31:0] idex_inst;
    logic [31:0] idex_src1;
    logic [31:0] idex_src2;
    logic [31:0] perf_stall_cnt;

    id_issue_stage #(.NOP_INST(NOP), .PERF_W(32)) dut (
        .clk(clk), .resetn(resetn), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .ex_ready(ex_ready), .flush(flush), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2), .stall_to_if(stall_to_if),
        .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_inst(idex_inst),
        .idex_src1(idex_src1), .idex_src2(idex_src2), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] s1;
        logic [31:0] s2;
    } slot_t;

    slot_t       m_ifid;
    slot_t       m_idex;
    logic [31:0] m_cnt;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [31:0] mk_lw(input logic [4:0] rt, input logic [4:0] rs);
        return {6'b100011, rs, rt, 16'h0000};
    endfunction

    function automatic logic [31:0] mk_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {6'b000000, rs, rt, rd, 5'b00000, 6'h20};
    endfunction

    // A load in EX blocks the ID instruction if it reads the load's nonzero target
    function automatic logic m_hazard();
        logic [4:0] rs, rt, dest;
        rs   = m_ifid.inst[25:21];
        rt   = m_ifid.inst[20:16];
        dest = m_idex.inst[20:16];
        return m_ifid.v && m_idex.v && (m_idex.inst[31:29] == 3'b100) && dest != 0 && (dest == rs || dest == rt);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_cnt;
`ifdef STALL_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 32'd0;
`endif
        check("stall_to_if", 32'(stall_to_if), 32'(resetn && !flush && (!ex_ready || m_hazard())));
        check("raddr1", 32'(raddr1), 32'(m_ifid.inst[25:21]));
        check("raddr2", 32'(raddr2), 32'(m_ifid.inst[20:16]));
        check("idex_valid", 32'(idex_valid), 32'(m_idex.v));
        check("idex_pc", idex_pc, m_idex.pc);
        check("idex_inst", idex_inst, m_idex.inst);
        check("idex_src1", idex_src1, m_idex.s1);
        check("idex_src2", idex_src2, m_idex.s2);
        check("perf_stall_cnt", perf_stall_cnt, exp_cnt);
    endtask

    task automatic model_reset();
        m_ifid = '{v: 1'b0, pc: 32'h0, inst: NOP, s1: 32'h0, s2: 32'h0};
        m_idex = '{v: 1'b0, pc: 32'h0, inst: NOP, s1: 32'h0, s2: 32'h0};
        m_cnt  = 32'h0;
    endtask

    task automatic model_edge();
        if (flush) begin
            m_ifid.v    = 1'b0;
            m_ifid.inst = NOP;
            m_idex.v    = 1'b0;
            m_idex.inst = NOP;
            m_idex.s1   = 32'h0;
            m_idex.s2   = 32'h0;
        end else if (!ex_ready) begin
            // everything holds
        end else if (m_hazard()) begin
            m_idex = '{v: 1'b0, pc: 32'h0, inst: NOP, s1: 32'h0, s2: 32'h0};
            m_cnt  = m_cnt + 32'd1;
        end else begin
            m_idex = '{v: m_ifid.v, pc: m_ifid.pc, inst: m_ifid.inst, s1: rdata1, s2: rdata2};
            if (if_valid) m_ifid = '{v: 1'b1, pc: if_pc, inst: if_inst, s1: 32'h0, s2: 32'h0};
            else begin
                m_ifid.v    = 1'b0;
                m_ifid.inst = NOP;
            end
        end
    endtask

    // Called with inputs already set, shortly after a negedge
    task automatic cycle();
        #1 check_all();
        @(posedge clk);
        model_edge();
        #1 check_all();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic exr, input logic fl);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        ex_ready = exr;
        flush    = fl;
        rdata1   = $urandom;
        rdata2   = $urandom;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1 model_reset();
        check_all();
        @(posedge clk);
        #1 check_all();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        model_reset();
        resetn = 1'b0;
        drive(1'b0, 32'h0, NOP, 1'b1, 1'b0);
        @(negedge clk);
        do_reset();

        // T2 load-use: lw $8 then add $9,$8,$2
        drive(1'b1, 32'h100, mk_lw(5'd8, 5'd1), 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h104, mk_add(5'd9, 5'd8, 5'd2), 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h108, mk_add(5'd10, 5'd11, 5'd12), 1'b1, 1'b0);
        #1 check("t2_stall", 32'(stall_to_if), 32'd1);
        cycle();
        check("t2_bubble", 32'(idex_valid), 32'd0);
        cycle();
        check("t2_add_issued", idex_pc, 32'h104);
        cycle(); cycle();

        // T3 $zero load never interlocks
        drive(1'b1, 32'h200, mk_lw(5'd0, 5'd1), 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h204, mk_add(5'd9, 5'd0, 5'd2), 1'b1, 1'b0); cycle();
        drive(1'b0, 32'h0, NOP, 1'b1, 1'b0);
        #1 check("t3_nostall", 32'(stall_to_if), 32'd0);
        cycle(); cycle();

        // T4 EX busy with load-use pending, then release
        drive(1'b1, 32'h300, mk_lw(5'd7, 5'd1), 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h304, mk_add(5'd9, 5'd2, 5'd7), 1'b1, 1'b0); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h308, mk_add(5'd1, 5'd2, 5'd3), 1'b0, 1'b0); cycle();
            check("t4_frozen", idex_pc, 32'h300);
        end
        drive(1'b1, 32'h308, mk_add(5'd1, 5'd2, 5'd3), 1'b1, 1'b0); cycle();
        check("t4_bubble", 32'(idex_valid), 32'd0);
        cycle(); cycle();

        // T5 flush on the hazard cycle
        drive(1'b1, 32'h400, mk_lw(5'd6, 5'd1), 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h404, mk_add(5'd9, 5'd6, 5'd2), 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h408, NOP, 1'b1, 1'b1);
        #1 check("t5_nostall", 32'(stall_to_if), 32'd0);
        cycle();
        check("t5_killed", 32'(idex_valid), 32'd0);

        // T6 operand capture
        drive(1'b1, 32'h500, mk_add(5'd3, 5'd4, 5'd5), 1'b1, 1'b0); cycle();
        drive(1'b0, 32'h0, NOP, 1'b1, 1'b0);
        rdata1 = 32'h1234_5678;
        rdata2 = 32'hFFFF_FFFF;
        #1 check("t6_raddr1", 32'(raddr1), 32'd4);
        check("t6_raddr2", 32'(raddr2), 32'd5);
        cycle();
        check("t6_src1", idex_src1, 32'h1234_5678);
        check("t6_src2", idex_src2, 32'hFFFF_FFFF);

        // Randomized traffic over a small register set to provoke frequent hazards
        for (int n = 0; n < 1500; n++) begin
            logic [4:0]  a, b, c;
            logic [31:0] inst;
            a = 5'($urandom_range(0, 3));
            b = 5'($urandom_range(0, 3));
            c = 5'($urandom_range(0, 3));
            inst = ($urandom_range(0, 1) == 0) ? mk_lw(a, b) : mk_add(a, b, c);
            drive(1'($urandom_range(0, 3) != 0), $urandom, inst,
                  1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 19) == 0));
            cycle();
            // T1: asynchronous reset dropped mid-stream with EX busy
            if (n == 700) begin
                ex_ready = 1'b0;
                do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
